// File: rtl/dot_product_pipe.sv
// Pipelined N-tap dot product of unsigned pixels and signed weights with a
// valid/ready stream interface. Outputs the exact sum and a rounded, clamped pixel.
module dot_product_pipe #(
  parameter int unsigned NTAPS     = 4,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned WGT_W     = 9,
  parameter int unsigned FRAC_BITS = 7
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         clear,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [NTAPS*PIX_W-1:0]                       pix_in,
  input  logic [NTAPS*WGT_W-1:0]                       wgt_in,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic signed [PIX_W+WGT_W+$clog2(NTAPS)-1:0]  acc_out,
  output logic [PIX_W-1:0]                             pix_out,
  output logic                                         sat_hi,
  output logic                                         sat_lo
);

  localparam int unsigned LOG2N  = $clog2(NTAPS);
  localparam int unsigned PROD_W = PIX_W + WGT_W;
  localparam int unsigned ACC_W  = PROD_W + LOG2N;
  localparam logic signed [ACC_W:0] RND = ((ACC_W+1)'(1) << FRAC_BITS) >> 1;

  logic                     adv;
  logic [LOG2N:0]           v_q, v_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [PROD_W-1:0] prod_q [NTAPS];
  logic signed [PROD_W-1:0] prod_d [NTAPS];
  logic signed [ACC_W-1:0]  node_q [1:NTAPS-1];
  logic signed [ACC_W-1:0]  node_d [1:NTAPS-1];
  logic signed [ACC_W-1:0]  tree_w [2:2*NTAPS-1];

  logic signed [ACC_W:0]    sum_w, rnd_w;
  logic signed [ACC_W-1:0]  acc_q;
  logic [PIX_W-1:0]         pix_q, pix_d;
  logic                     sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;

  assign adv       = ~out_valid_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign pix_out   = pix_q;
  assign sat_hi    = sat_hi_q;
  assign sat_lo    = sat_lo_q;

  always_comb begin
    for (int unsigned i = 0; i < NTAPS; i++) begin
      prod_d[i] = PROD_W'($signed({1'b0, pix_in[i*PIX_W +: PIX_W]}))
                * PROD_W'($signed(wgt_in[i*WGT_W +: WGT_W]));
    end
  end

  // Adder tree in heap order: node j sums children 2j and 2j+1, leaves NTAPS..2*NTAPS-1
  // are the products. Every node updates on adv, so depth d lands in stage LOG2N-d.
  always_comb begin
    for (int unsigned i = 0; i < NTAPS; i++) begin
      tree_w[NTAPS+i] = ACC_W'(prod_q[i]);
    end
    for (int unsigned j = 2; j < NTAPS; j++) begin
      tree_w[j] = node_q[j];
    end
    for (int unsigned j = 1; j < NTAPS; j++) begin
      node_d[j] = tree_w[2*j] + tree_w[2*j+1];
    end
  end

  always_comb begin
    sum_w    = {node_q[1][ACC_W-1], node_q[1]} + RND;
    rnd_w    = sum_w >>> FRAC_BITS;
    sat_lo_d = rnd_w[ACC_W];
    sat_hi_d = ~rnd_w[ACC_W] & (|rnd_w[ACC_W-1:PIX_W]);
    if (sat_lo_d) begin
      pix_d = '0;
    end else if (sat_hi_d) begin
      pix_d = '1;
    end else begin
      pix_d = rnd_w[PIX_W-1:0];
    end
  end

  always_comb begin
    v_d         = v_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      v_d         = '0;
      out_valid_d = 1'b0;
    end else if (adv) begin
      v_d         = {v_q[LOG2N-1:0], in_valid};
      out_valid_d = v_q[LOG2N];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        prod_q[i] <= '0;
      end
      for (int unsigned j = 1; j < NTAPS; j++) begin
        node_q[j] <= '0;
      end
      acc_q    <= '0;
      pix_q    <= '0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        prod_q[i] <= prod_d[i];
      end
      for (int unsigned j = 1; j < NTAPS; j++) begin
        node_q[j] <= node_d[j];
      end
      acc_q    <= node_q[1];
      pix_q    <= pix_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end

endmodule

// File: tb/tb_dot_product_pipe.sv
// Self-checking bench for dot_product_pipe: directed corner cases plus randomized
// backpressure traffic scored against an arithmetic reference model.
module tb_dot_product_pipe;

  localparam int NTAPS     = 4;
  localparam int PIX_W     = 8;
  localparam int WGT_W     = 9;
  localparam int FRAC_BITS = 7;
  localparam int ACC_W     = PIX_W + WGT_W + $clog2(NTAPS);
  localparam int LAT       = 2 + $clog2(NTAPS);

  logic                     clk = 1'b0;
  logic                     rst_n, clear, in_valid, in_ready;
  logic                     out_valid, out_ready, sat_hi, sat_lo;
  logic [NTAPS*PIX_W-1:0]   pix_in;
  logic [NTAPS*WGT_W-1:0]   wgt_in;
  logic signed [ACC_W-1:0]  acc_out;
  logic [PIX_W-1:0]         pix_out;

  dot_product_pipe #(
    .NTAPS(NTAPS), .PIX_W(PIX_W), .WGT_W(WGT_W), .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .pix_in(pix_in), .wgt_in(wgt_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .pix_out(pix_out),
    .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint acc;
    int     pix;
    bit     hi;
    bit     lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_out = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [NTAPS*PIX_W-1:0] p, input logic [NTAPS*WGT_W-1:0] w);
    exp_t               e;
    longint             s;
    longint             r;
    longint             den;
    logic [WGT_W-1:0]   wr;
    s = 0;
    for (int i = 0; i < NTAPS; i++) begin
      wr = w[i*WGT_W +: WGT_W];
      s += longint'(p[i*PIX_W +: PIX_W]) * longint'($signed(wr));
    end
    den = longint'(1) << FRAC_BITS;
    r   = s + den / 2;
    // floor division, rounding toward minus infinity
    r   = (r >= 0) ? r / den : -((-r + den - 1) / den);
    e.acc = s;
    e.lo  = (r < 0);
    e.hi  = (r > (2**PIX_W) - 1);
    e.pix = e.lo ? 0 : (e.hi ? (2**PIX_W) - 1 : int'(r));
    return e;
  endfunction

  // Scoreboard / protocol monitor, sampling on the falling edge.
  logic                    stall_prev = 1'b0;
  logic                    clr_prev   = 1'b0;
  logic signed [ACC_W-1:0] s_acc;
  logic [PIX_W-1:0]        s_pix;
  logic [1:0]              s_fl;
  exp_t                    e_mon;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      clr_prev   = 1'b0;
    end else begin
      chk("in_ready_adv", in_ready, !out_valid || out_ready);
      if (stall_prev && !clr_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_acc", acc_out, s_acc);
        chk("hold_pix", pix_out, s_pix);
        chk("hold_flags", {sat_hi, sat_lo}, s_fl);
      end
      if (out_valid) chk("sat_exclusive", sat_hi & sat_lo, 0);
      if (out_valid && out_ready) begin
        chk("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e_mon = exp_q.pop_front();
          chk("sb_acc", acc_out, e_mon.acc);
          chk("sb_pix", pix_out, e_mon.pix);
          chk("sb_sat_hi", sat_hi, e_mon.hi);
          chk("sb_sat_lo", sat_lo, e_mon.lo);
          n_out++;
        end
      end
      if (clear) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(pix_in, wgt_in));
      stall_prev = out_valid && !out_ready;
      clr_prev   = clear;
      s_acc      = acc_out;
      s_pix      = pix_out;
      s_fl       = {sat_hi, sat_lo};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    pix_in = $urandom;
    wgt_in = (NTAPS*WGT_W)'({$urandom, $urandom});
  endtask

  task automatic directed(input string tag, input logic [NTAPS*PIX_W-1:0] p,
                          input logic [NTAPS*WGT_W-1:0] w, input longint e_acc,
                          input int e_pix, input bit e_hi, input bit e_lo);
    int n;
    pix_in    = p;
    wgt_in    = w;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 4*LAT) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_acc"}, acc_out, e_acc);
    chk({tag, "_pix"}, pix_out, e_pix);
    chk({tag, "_sat_hi"}, sat_hi, e_hi);
    chk({tag, "_sat_lo"}, sat_lo, e_lo);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int sent, base, cyc;
    bit acc_now;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pix_in = '0;  wgt_in = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_pix", pix_out, 0);
    chk("rst_sat_hi", sat_hi, 0);
    chk("rst_sat_lo", sat_lo, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle_in_ready", in_ready, 1);

    directed("t1", {4{8'd100}}, {4{9'd32}}, 12800, 100, 0, 0);
    directed("t2", {8'd0, 8'd255, 8'd255, 8'd0}, {9'h1F0, 9'd80, 9'd80, 9'h1F0}, 40800, 255, 1, 0);
    directed("t3", {8'd255, 8'd0, 8'd0, 8'd255}, {9'h1F0, 9'd80, 9'd80, 9'h1F0}, -8160, 0, 0, 1);
    directed("t4_round_up", {8'd0, 8'd0, 8'd0, 8'd1}, {9'd0, 9'd0, 9'd0, 9'd64}, 64, 1, 0, 0);
    directed("t4_round_dn", {8'd0, 8'd0, 8'd0, 8'd1}, {9'd0, 9'd0, 9'd0, 9'd63}, 63, 0, 0, 0);
    directed("t4_neg_zero", {8'd0, 8'd0, 8'd0, 8'd1}, {9'd0, 9'd0, 9'd0, 9'h1C0}, -64, 0, 0, 0);
    directed("t4_neg_one", {8'd0, 8'd0, 8'd0, 8'd1}, {9'd0, 9'd0, 9'd0, 9'h1BF}, -65, 0, 0, 1);
    directed("t4_top_ok", {8'd0, 8'd0, 8'd0, 8'd255}, {9'd0, 9'd0, 9'd0, 9'd128}, 32640, 255, 0, 0);
    directed("t4_top_sat", {8'd0, 8'd0, 8'd1, 8'd255}, {9'd0, 9'd0, 9'd64, 9'd128}, 32704, 255, 1, 0);
    directed("t4_extreme", {4{8'd255}}, {4{9'h100}}, -261120, 0, 0, 1);

    // T5: back-to-back random beats under random backpressure
    sent = 0; base = n_out; cyc = 0;
    rand_beat();
    in_valid = 1'b1;
    while ((sent < 20 || exp_q.size() > 0) && cyc < 600) begin
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc_now = in_valid && in_ready;
      step();
      if (acc_now) begin
        sent++;
        if (sent < 20) rand_beat();
        else in_valid = 1'b0;
      end
      cyc++;
    end
    chk("t5_outputs", n_out - base, 20);
    chk("t5_drained", exp_q.size(), 0);

    // T6a: clear with three beats in flight; a fourth beat offered alongside clear
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_beat();
      step();
    end
    rand_beat();
    clear = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("t6_clear_valid", out_valid, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t6_clear_quiet", out_valid, 0);
    end
    directed("t6_post_clear", {4{8'd100}}, {4{9'd32}}, 12800, 100, 0, 0);

    // T6b: asynchronous reset while the pipe is full and streaming
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rand_beat();
      step();
    end
    chk("t6_pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_acc", acc_out, 0);
    chk("t6_rst_pix", pix_out, 0);
    chk("t6_rst_sat_hi", sat_hi, 0);
    chk("t6_rst_sat_lo", sat_lo, 0);
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t6_rst_quiet", out_valid, 0);
    end
    directed("t6_post_reset", {8'd0, 8'd255, 8'd255, 8'd0}, {9'h1F0, 9'd80, 9'd80, 9'h1F0}, 40800, 255, 1, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
